// File: rtl/sw_debounce_step.sv
// ---------------------------------------------------------------------------
// sw_debounce_step
//
// Input conditioning for the LED blink-rate counter. The slide switches are
// synchronised into the CLOCK_50 domain. Each bit is then debounced on its
// own against a shared sample tick. The block presents a clean vector, a
// one-cycle change pulse and a registered counter step that is never zero.
//
// Ports:
//   CLOCK_50    in   1  system clock, all state on the rising edge
//   RESET_N     in   1  asynchronous, active-low reset
//   SW          in   W  raw slide switches (asynchronous, bouncing)
//   sw_clean    out  W  debounced switch vector
//   sw_changed  out  1  one-cycle pulse in the cycle sw_clean takes a new value
//   step        out  W  counter increment: sw_clean with 0 replaced by 1
// ---------------------------------------------------------------------------
module sw_debounce_step #(
  parameter int CLK_HZ       = 50000000,
  parameter int TICK_HZ      = 1000,
  parameter int STABLE_TICKS = 10,
  parameter int W            = 10
) (
  input  logic         CLOCK_50,
  input  logic         RESET_N,
  input  logic [W-1:0] SW,
  output logic [W-1:0] sw_clean,
  output logic         sw_changed,
  output logic [W-1:0] step
);

  // Prescaler period in clock cycles. CLK_HZ/TICK_HZ must divide exactly, and
  // the period must be at least 2.
  localparam int P  = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(P);
  localparam int CW = $clog2(STABLE_TICKS + 1);

  // A bit is accepted on the tick that would take its count to STABLE_TICKS.
  // Comparing against STABLE_TICKS-1 before the increment means the counter
  // never has to hold STABLE_TICKS.
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  // Per-bit debounce state. The state is derived from the data and is not
  // stored: a bit is PENDING exactly when the synchronised input differs from
  // its clean value.
  localparam logic [0:0] ST_STABLE  = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [W-1:0]  sync1;
  logic [W-1:0]  sync2;
  logic [PW-1:0] presc;
  logic          tick;
  logic [CW-1:0] cnt [W];
  logic [W-1:0]  state;
  logic [W-1:0]  accept;
  logic [W-1:0]  clean_next;

  // Two-flop synchroniser. Nothing downstream looks at sync1.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples its
  // inputs from before the edge, whatever order the statements are in.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= SW;
      sync2 <= sync1;
    end
  end

  // Free-running prescaler that counts 0..P-1. tick is high for the whole
  // terminal-count cycle.
  assign tick = (presc == PW'(P - 1));

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Decode the per-bit state and the accepts. An accepted bit always differs
  // from its clean value, so the new clean vector is a simple XOR.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state  = '0;
    accept = '0;
    for (int i = 0; i < W; i++) begin
      state[i]  = (sync2[i] != sw_clean[i]) ? ST_PENDING : ST_STABLE;
      accept[i] = (state[i] == ST_PENDING) && tick && (cnt[i] == CNT_LAST);
    end
    clean_next = sw_clean ^ accept;
  end

  // Tick counters. Any cycle where the input agrees with clean restarts the
  // count, so a glitch that does not last STABLE_TICKS ticks is never accepted.
  // NOTE: this small counter array is reset explicitly. A pending count left
  // over from before reset must not shorten the first acceptance after it.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < W; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        if (state[i] == ST_STABLE || accept[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // All three outputs are registered from the same clean_next value, so they
  // update together. Several bits accepted on one tick give a single pulse.
  // step resets to 1 so it is never zero, even in the first cycle after reset.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_clean   <= '0;
      sw_changed <= 1'b0;
      step       <= W'(1);
    end else begin
      sw_clean   <= clean_next;
      sw_changed <= |accept;
      step       <= (clean_next == '0) ? W'(1) : clean_next;
    end
  end

endmodule

// File: tb/tb_sw_debounce_step.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce_step
//
// Self-checking bench for sw_debounce_step, using P=10 and STABLE_TICKS=3.
// A behavioural model runs alongside the DUT. For each bit it remembers the
// last clock edge at which the synchronised input agreed with the clean
// value. A bit is accepted at the tick edge where the number of ticks since
// that edge, counted arithmetically, reaches STABLE_TICKS.
// ---------------------------------------------------------------------------
module tb_sw_debounce_step;

  localparam int W  = 10;
  localparam int P  = 10;
  localparam int ST = 3;

  logic         CLOCK_50 = 1'b0;
  logic         RESET_N  = 1'b0;
  logic [W-1:0] SW       = '0;
  logic [W-1:0] sw_clean;
  logic         sw_changed;
  logic [W-1:0] step;

  sw_debounce_step #(
    .CLK_HZ      (100),
    .TICK_HZ     (10),
    .STABLE_TICKS(ST),
    .W           (W)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .SW        (SW),
    .sw_clean  (sw_clean),
    .sw_changed(sw_changed),
    .step      (step)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  // Model state. e is the index of the next clock edge after reset release.
  int           e;
  logic [W-1:0] m_clean;
  logic [W-1:0] m_step;
  logic         m_changed;
  int           last_eq [W];
  logic [W-1:0] hist [$];
  int           pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Number of tick edges t, with a < t <= b. Tick edges are those with
  // t mod P == P-1.
  function automatic int ticks_between(input int a, input int b);
    return (b + 1) / P - (a + 1) / P;
  endfunction

  task automatic model_reset();
    e         = 0;
    m_clean   = '0;
    m_step    = W'(1);
    m_changed = 1'b0;
    hist.delete();
    foreach (last_eq[i]) last_eq[i] = -1;
  endtask

  task automatic model_edge(input logic [W-1:0] sw);
    logic [W-1:0] s;
    logic [W-1:0] nxt;
    bit           tk;
    // The debouncer sees the switch value from two edges earlier.
    s   = (hist.size() == 2) ? hist[0] : '0;
    tk  = (e % P == P - 1);
    nxt = m_clean;
    for (int i = 0; i < W; i++) begin
      if (s[i] == m_clean[i]) begin
        last_eq[i] = e;
      end else if (tk && ticks_between(last_eq[i], e) >= ST) begin
        nxt[i]     = s[i];
        last_eq[i] = e;
      end
    end
    m_changed = (nxt != m_clean);
    m_clean   = nxt;
    m_step    = (nxt == '0) ? W'(1) : nxt;
    hist.push_back(sw);
    if (hist.size() > 2) void'(hist.pop_front());
    e++;
  endtask

  task automatic compare_outputs();
    check("sw_clean", sw_clean, m_clean);
    check("sw_changed", sw_changed, m_changed);
    check("step", step, m_step);
    if (sw_changed) pulses++;
  endtask

  // One clock cycle. The caller starts at a falling edge. SW is applied at
  // once, the model advances at the rising edge, and the outputs are compared
  // at the next falling edge.
  task automatic cyc(input logic [W-1:0] sw);
    SW = sw;
    @(posedge CLOCK_50);
    if (RESET_N) model_edge(sw);
    else         model_reset();
    @(negedge CLOCK_50);
    compare_outputs();
  endtask

  // Hold sw for n cycles. Report the first cycle (1-based) in which sw_clean
  // equals target, or -1 if it never does. pulses counts sw_changed highs.
  task automatic run_measure(input logic [W-1:0] sw, input int n,
                             input logic [W-1:0] target, output int first);
    pulses = 0;
    first  = -1;
    for (int c = 1; c <= n; c++) begin
      cyc(sw);
      if (first < 0 && sw_clean == target) first = c;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_clean"}, sw_clean, 0);
    check({tag, "_step"}, step, 1);
    check({tag, "_changed"}, sw_changed, 0);
  endtask

  initial begin
    int           first;
    logic [W-1:0] target;
    logic [W-1:0] sw;
    logic [W-1:0] one_hot;
    int           hold;

    model_reset();
    pulses = 0;

    // Reset with every switch high, then release.
    RESET_N = 1'b0;
    repeat (4) cyc(10'h3FF);
    check_reset_values("rst_hold");
    RESET_N = 1'b1;
    run_measure(10'h3FF, 40, 10'h3FF, first);
    check($sformatf("rst_accept_lat_%0d", first), (first >= 1 && first <= 33), 1);
    check("rst_accept_pulses", pulses, 1);
    check("rst_accept_step", step, 10'h3FF);
    repeat (40) cyc(10'h000);

    // Clean change from 0 to 005.
    run_measure(10'h005, 40, 10'h005, first);
    check($sformatf("clean_lat_%0d", first), (first >= 23 && first <= 33), 1);
    check("clean_pulses", pulses, 1);
    check("clean_step", step, 10'h005);
    repeat (40) cyc(10'h000);

    // Bounce: SW[0] toggles every 7 cycles, and the final rising edge is at 98.
    pulses = 0;
    for (int c = 0; c < 98; c++) cyc(((c / 7) % 2 == 0) ? 10'h001 : 10'h000);
    check("bounce_no_pulse", pulses, 0);
    run_measure(10'h001, 40, 10'h001, first);
    check($sformatf("bounce_lat_%0d", first), (first >= 1 && first <= 33), 1);
    check("bounce_pulses", pulses, 1);

    // Short glitch on SW[3] for 25 cycles. It is phased so that the
    // synchronised high window covers exactly two ticks.
    for (int k = 0; k < P && ((e + 2) % P != 0); k++) cyc(10'h001);
    pulses = 0;
    repeat (25) cyc(10'h009);
    repeat (40) cyc(10'h001);
    check("glitch_no_pulse", pulses, 0);
    check("glitch_bit3", sw_clean[3], 0);

    // Zero step: accept 004, then accept 0.
    repeat (40) cyc(10'h004);
    check("zero_pre_clean", sw_clean, 10'h004);
    run_measure(10'h000, 40, 10'h000, first);
    check("zero_clean", sw_clean, 0);
    check("zero_step", step, 1);
    check("zero_pulses", pulses, 1);

    // Reset mid-count. It is asserted between clock edges and released 3 cycles later.
    repeat (15) cyc(10'h020);
    #3 RESET_N = 1'b0;
    #1 check_reset_values("rst_mid_async");
    model_reset();
    repeat (3) cyc(10'h020);
    RESET_N = 1'b1;
    run_measure(10'h020, 40, 10'h020, first);
    check($sformatf("rst_mid_lat_%0d", first), (first >= 23 && first <= 33), 1);
    check("rst_mid_pulses", pulses, 1);

    // Randomised holds with occasional single-bit bounce.
    for (int seg = 0; seg < 60; seg++) begin
      target = W'($urandom);
      hold   = $urandom_range(1, 60);
      for (int h = 0; h < hold; h++) begin
        sw = target;
        if ($urandom_range(0, 7) == 0) begin
          one_hot = W'(1) << $urandom_range(0, W - 1);
          sw      = sw ^ one_hot;
        end
        cyc(sw);
      end
    end

    // Asynchronous reset while the outputs hold a non-trivial value.
    repeat (40) cyc(10'h2A5);
    check("pre_async_clean", sw_clean, 10'h2A5);
    #3 RESET_N = 1'b0;
    #1 check_reset_values("rst_async_live");
    model_reset();
    repeat (2) cyc(10'h2A5);
    RESET_N = 1'b1;
    repeat (40) cyc(10'h2A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
